// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add multiplier, one multiplier bit per clock.
// Operands are captured with start, reduced to magnitudes, multiplied
// unsigned over WIDTH cycles, and the product is negated at the end when the
// operand signs differed (signed mode only).
//
// Handshake: start is accepted on any rising edge where busy=0 (IDLE or
// DONE); busy is high for exactly WIDTH cycles while the product is being
// formed; done is a one-cycle pulse in the cycle after the last CALC cycle,
// and product holds its value from that pulse until the next done.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [1:0]           dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH:0]     acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic                 accept;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH:0]     acc_shifted;
  logic [2*WIDTH-1:0]   prod_mag;

  // A new operation can start whenever no multiply is in flight.
  assign accept = start && (state_q != S_CALC);

  // Operand magnitudes and one shift-add step of the accumulator.
  always_comb begin
    a_mag       = (signed_mode && a[WIDTH-1]) ? (-a) : a;
    b_mag       = (signed_mode && b[WIDTH-1]) ? (-b) : b;
    sum         = acc_q[2*WIDTH:WIDTH] + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_shifted = {sum, acc_q[WIDTH-1:0]} >> 1;
    prod_mag    = acc_shifted[2*WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CALC;
      S_CALC:  if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = start ? S_CALC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: capture on accept, iterate in CALC, load product on the last step.
  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    if (accept) begin
      mcand_d  = a_mag;
      mplier_d = b_mag;
      neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      acc_d    = '0;
      cnt_d    = CW'(WIDTH - 1);
    end else if (state_q == S_CALC) begin
      acc_d    = acc_shifted;
      mplier_d = mplier_q >> 1;
      if (cnt_q == '0) begin
        product_d = neg_q ? (-prod_mag) : prod_mag;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // Datapath registers; reset clears everything, aborting any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    busy      = (state_q == S_CALC);
    done      = (state_q == S_DONE);
    product   = product_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed and random checks of seq_multiplier at WIDTH=8
// and an exhaustive sweep at WIDTH=2, with expected products queued at start.
module tb_seq_multiplier;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;
  logic [1:0]  st8;

  logic        start2, sm2, busy2, done2;
  logic [1:0]  a2, b2;
  logic [3:0]  prod2;
  logic [1:0]  st2;

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(prod8),
    .dbg_state(st8)
  );

  seq_multiplier #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .signed_mode(sm2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .product(prod2),
    .dbg_state(st2)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [3:0]  exp_q2[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y,
                                         input logic sm);
    int ix, iy, p;
    ix = sm ? {{24{x[7]}}, x} : {24'b0, x};
    iy = sm ? {{24{y[7]}}, y} : {24'b0, y};
    p  = ix * iy;
    return p[15:0];
  endfunction

  function automatic logic [3:0] model2(input logic [1:0] x, input logic [1:0] y,
                                        input logic sm);
    int ix, iy, p;
    ix = sm ? {{30{x[1]}}, x} : {30'b0, x};
    iy = sm ? {{30{y[1]}}, y} : {30'b0, y};
    p  = ix * iy;
    return p[3:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at the negedge right after the capturing edge; returns at the
  // negedge where done is seen (or after the cycle budget runs out).
  task automatic wait_done8(input string tag, output int cycles, output int busy_n);
    cycles = 0;
    busy_n = 0;
    while (done8 !== 1'b1 && cycles < 40) begin
      if (busy8 === 1'b1) busy_n++;
      @(negedge clk);
      cycles++;
    end
    check({tag, "_done_seen"}, {31'b0, done8}, 32'd1);
    check({tag, "_busy_at_done"}, {31'b0, busy8}, 32'd0);
  endtask

  task automatic op8(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                     input logic sm, input logic [15:0] expv);
    int cycles, busy_n;
    logic [15:0] e;
    @(negedge clk);
    a8 = xa; b8 = xb; sm8 = sm; start8 = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(tag, cycles, busy_n);
    check({tag, "_latency"}, cycles, 32'd8);
    check({tag, "_busy_cycles"}, busy_n, 32'd8);
    e = exp_q.pop_front();
    check({tag, "_product"}, {16'b0, prod8}, {16'b0, e});
  endtask

  task automatic op2(input logic [1:0] xa, input logic [1:0] xb, input logic sm);
    int cycles;
    logic [3:0] e;
    @(negedge clk);
    a2 = xa; b2 = xb; sm2 = sm; start2 = 1'b1;
    exp_q2.push_back(model2(xa, xb, sm));
    @(negedge clk);
    start2 = 1'b0;
    cycles = 0;
    while (done2 !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    check($sformatf("w2_latency_a%0d_b%0d_s%0d", xa, xb, sm), cycles, 32'd2);
    e = exp_q2.pop_front();
    check($sformatf("w2_product_a%0d_b%0d_s%0d", xa, xb, sm), {28'b0, prod2}, {28'b0, e});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int n, bn, stamp, prev, extra;
    logic [7:0] xa, xb;
    logic xs;
    logic [15:0] e;

    rst_n = 1'b0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    start2 = 1'b0; sm2 = 1'b0; a2 = '0; b2 = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", {31'b0, busy8}, 32'd0);
    check("rst_done", {31'b0, done8}, 32'd0);
    check("rst_product", {16'b0, prod8}, 32'd0);
    check("rst_product_w2", {28'b0, prod2}, 32'd0);
    rst_n = 1'b1;

    // Unsigned maximum, then product must hold after done
    op8("u_ff_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    repeat (3) @(negedge clk);
    check("hold_product", {16'b0, prod8}, 32'h0000FE01);
    check("hold_done_low", {31'b0, done8}, 32'd0);
    check("hold_busy_low", {31'b0, busy8}, 32'd0);

    // Signed boundaries
    op8("s_80_80", 8'h80, 8'h80, 1'b1, 16'h4000);
    op8("s_80_7f", 8'h80, 8'h7F, 1'b1, 16'hC080);
    op8("s_fd_05", 8'hFD, 8'h05, 1'b1, 16'hFFF1);
    op8("s_zero",  8'h00, 8'h93, 1'b1, 16'h0000);

    // Random operands, both modes
    for (int r = 0; r < 6; r++) begin
      xa = 8'($urandom_range(0, 255));
      xb = 8'($urandom_range(0, 255));
      xs = 1'($urandom_range(0, 1));
      op8("rand", xa, xb, xs, model8(xa, xb, xs));
    end

    // WIDTH=2 exhaustive
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          op2(i[1:0], j[1:0], m[0]);

    // Back-to-back: start held high for three operations
    prev = 0;
    @(negedge clk);
    a8 = 8'd17; b8 = 8'd23; sm8 = 1'b0; start8 = 1'b1;
    exp_q.push_back(model8(8'd17, 8'd23, 1'b0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n = 0;
      while (done8 !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("b2b_done_seen", {31'b0, done8}, 32'd1);
      stamp = cyc;
      if (i > 0) check("b2b_spacing", stamp - prev, 32'd9);
      prev = stamp;
      e = exp_q.pop_front();
      check("b2b_product", {16'b0, prod8}, {16'b0, e});
      if (i == 0) begin
        a8 = 8'hF6; b8 = 8'h0D; sm8 = 1'b1;
        exp_q.push_back(model8(8'hF6, 8'h0D, 1'b1));
      end else if (i == 1) begin
        a8 = 8'hC8; b8 = 8'h64; sm8 = 1'b0;
        exp_q.push_back(model8(8'hC8, 8'h64, 1'b0));
      end else begin
        start8 = 1'b0;
      end
    end

    // start pulsed while busy is ignored
    @(negedge clk);
    a8 = 8'd12; b8 = 8'd11; sm8 = 1'b0; start8 = 1'b1;
    exp_q.push_back(16'd132);
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'd200; b8 = 8'd200; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8("busy_start", n, bn);
    e = exp_q.pop_front();
    check("busy_start_product", {16'b0, prod8}, {16'b0, e});
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) extra++;
    end
    check("busy_start_no_extra_op", extra, 32'd0);
    check("busy_start_product_held", {16'b0, prod8}, 32'd132);

    // Operand churn during CALC
    @(negedge clk);
    a8 = 8'h9C; b8 = 8'hB5; sm8 = 1'b1; start8 = 1'b1;
    exp_q.push_back(model8(8'h9C, 8'hB5, 1'b1));
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (done8 !== 1'b1 && n < 40) begin
      a8  = 8'($urandom_range(0, 255));
      b8  = 8'($urandom_range(0, 255));
      sm8 = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    check("churn_done_seen", {31'b0, done8}, 32'd1);
    check("churn_latency", n, 32'd8);
    e = exp_q.pop_front();
    check("churn_product", {16'b0, prod8}, {16'b0, e});

    // Reset in the fourth CALC cycle aborts the operation
    @(negedge clk);
    a8 = 8'd250; b8 = 8'd251; sm8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("midop_busy_before", {31'b0, busy8}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midop_rst_busy", {31'b0, busy8}, 32'd0);
    check("midop_rst_done", {31'b0, done8}, 32'd0);
    check("midop_rst_product", {16'b0, prod8}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done8 === 1'b1) extra++;
    end
    check("midop_no_done", extra, 32'd0);
    op8("after_rst_3x7", 8'd3, 8'd7, 1'b0, 16'd21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
